// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: forwarding select, data-hazard stalls, memory-wait freeze with timeout.
// Optional forwarding is enabled by defining PIPE_FORWARD_EN (default build: no forwarding, stall on any RAW).
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_useRs,
  input  logic        id_useRt,
  input  logic [4:0]  exe_WriteRegDst,
  input  logic        exe_ALUToReg,
  input  logic        exe_MemToReg,
  input  logic [4:0]  mem_WriteRegDst,
  input  logic        mem_ALUToReg,
  input  logic        mem_MemToReg,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idexe_stall,
  output logic        exemem_stall,
  output logic        ifid_flush,
  output logic        idexe_flush,
  output logic [1:0]  fwdA,
  output logic [1:0]  fwdB,
  output logic        mem_err,
  output logic [15:0] stall_cnt,
  output logic        dbg_state
);

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        mem_err_q, mem_err_d;

  logic exe_wr, mem_wr;
  logic exe_hit_rs, exe_hit_rt, mem_hit_rs, mem_hit_rt;
  logic data_hazard, timeout, freeze;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // Register 0 is hard-wired zero, so it never creates a dependency.
  assign exe_wr     = exe_ALUToReg | exe_MemToReg;
  assign mem_wr     = mem_ALUToReg | mem_MemToReg;
  assign exe_hit_rs = exe_wr && id_useRs && (id_rs != 5'd0) && (exe_WriteRegDst == id_rs);
  assign exe_hit_rt = exe_wr && id_useRt && (id_rt != 5'd0) && (exe_WriteRegDst == id_rt);
  assign mem_hit_rs = mem_wr && id_useRs && (id_rs != 5'd0) && (mem_WriteRegDst == id_rs);
  assign mem_hit_rt = mem_wr && id_useRt && (id_rt != 5'd0) && (mem_WriteRegDst == id_rt);

`ifdef PIPE_FORWARD_EN
  assign data_hazard = exe_MemToReg && (exe_hit_rs || exe_hit_rt);
  assign fwd_a_raw   = exe_hit_rs ? 2'b01 : (mem_hit_rs ? 2'b10 : 2'b00);
  assign fwd_b_raw   = exe_hit_rt ? 2'b01 : (mem_hit_rt ? 2'b10 : 2'b00);
`else
  assign data_hazard = exe_hit_rs | exe_hit_rt | mem_hit_rs | mem_hit_rt;
  assign fwd_a_raw   = 2'b00;
  assign fwd_b_raw   = 2'b00;
`endif

  // Memory handshake: mem_req marks a MEM-stage RAM access; the access completes
  // in the cycle mem_ready is high. Until then the whole pipe is frozen.
  assign timeout = (state_q == MEMWAIT) && (wait_q == 8'hFF);
  assign freeze  = ((state_q == RUN) && mem_req && !mem_ready) ||
                   ((state_q == MEMWAIT) && !mem_ready && !timeout);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_q      <= 8'd0;
      stall_cnt_q <= 16'd0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = 1'b0;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = MEMWAIT;
          wait_d  = 8'd0;
        end
      end
      MEMWAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else if (timeout) begin
          state_d   = RUN;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Priority: reset > freeze > data hazard > structural conflict > branch.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idexe_stall  = 1'b0;
    exemem_stall = 1'b0;
    ifid_flush   = 1'b0;
    idexe_flush  = 1'b0;
    fwdA         = fwd_a_raw;
    fwdB         = fwd_b_raw;
    if (!rst) begin
      ifid_flush  = 1'b1;
      idexe_flush = 1'b1;
      fwdA        = 2'b00;
      fwdB        = 2'b00;
    end else if (freeze) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idexe_stall  = 1'b1;
      exemem_stall = 1'b1;
    end else if (data_hazard) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idexe_flush = 1'b1;
    end else if (mem_req) begin
      ifid_flush = 1'b1;
      pc_stall   = !branch_taken;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

  assign stall_cnt_d = (pc_stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  assign stall_cnt = stall_cnt_q;
  assign mem_err   = mem_err_q;
  assign dbg_state = (state_q == MEMWAIT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard/wait/timeout/reset scenarios plus random stimulus
// compared cycle by cycle against a behavioural model of the control rules.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt;
  logic        id_useRs, id_useRt;
  logic [4:0]  exe_WriteRegDst;
  logic        exe_ALUToReg, exe_MemToReg;
  logic [4:0]  mem_WriteRegDst;
  logic        mem_ALUToReg, mem_MemToReg;
  logic        mem_req, mem_ready, branch_taken;
  logic        pc_stall, ifid_stall, idexe_stall, exemem_stall;
  logic        ifid_flush, idexe_flush;
  logic [1:0]  fwdA, fwdB;
  logic        mem_err;
  logic [15:0] stall_cnt;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;

  // model state
  bit          m_wait;
  int          m_waited;
  bit          m_err;
  logic [15:0] exp_q[$];
  bit          e_pc, e_ifid, e_idexe, e_exemem, e_fl1, e_fl2;
  logic [1:0]  e_fa, e_fb;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_useRs(id_useRs), .id_useRt(id_useRt),
    .exe_WriteRegDst(exe_WriteRegDst), .exe_ALUToReg(exe_ALUToReg), .exe_MemToReg(exe_MemToReg),
    .mem_WriteRegDst(mem_WriteRegDst), .mem_ALUToReg(mem_ALUToReg), .mem_MemToReg(mem_MemToReg),
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idexe_stall(idexe_stall), .exemem_stall(exemem_stall),
    .ifid_flush(ifid_flush), .idexe_flush(idexe_flush),
    .fwdA(fwdA), .fwdB(fwdB), .mem_err(mem_err), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reads(input logic use_r, input logic [4:0] r, input logic [4:0] dst, input logic wr);
    return (use_r == 1'b1) && (wr == 1'b1) && (r != 5'd0) && (r == dst);
  endfunction

  function automatic bit model_freeze();
    if (m_wait) return !mem_ready && (m_waited < 255);
    return mem_req && !mem_ready;
  endfunction

  task automatic model_reset();
    m_wait   = 1'b0;
    m_waited = 0;
    m_err    = 1'b0;
    exp_q.delete();
    exp_q.push_back(16'd0);
  endtask

  task automatic model_comb();
    bit a_exe, a_mem, b_exe, b_mem, haz;
    {e_pc, e_ifid, e_idexe, e_exemem, e_fl1, e_fl2} = '0;
    e_fa = 2'b00;
    e_fb = 2'b00;
    if (!rst) begin
      e_fl1 = 1'b1;
      e_fl2 = 1'b1;
      return;
    end
    a_exe = reads(id_useRs, id_rs, exe_WriteRegDst, exe_ALUToReg | exe_MemToReg);
    b_exe = reads(id_useRt, id_rt, exe_WriteRegDst, exe_ALUToReg | exe_MemToReg);
    a_mem = reads(id_useRs, id_rs, mem_WriteRegDst, mem_ALUToReg | mem_MemToReg);
    b_mem = reads(id_useRt, id_rt, mem_WriteRegDst, mem_ALUToReg | mem_MemToReg);
`ifdef PIPE_FORWARD_EN
    haz  = exe_MemToReg && (a_exe || b_exe);
    e_fa = a_exe ? 2'b01 : (a_mem ? 2'b10 : 2'b00);
    e_fb = b_exe ? 2'b01 : (b_mem ? 2'b10 : 2'b00);
`else
    haz  = a_exe || b_exe || a_mem || b_mem;
`endif
    if (model_freeze()) begin
      {e_pc, e_ifid, e_idexe, e_exemem} = 4'b1111;
    end else if (haz) begin
      e_pc = 1'b1; e_ifid = 1'b1; e_fl2 = 1'b1;
    end else if (mem_req) begin
      e_fl1 = 1'b1; e_pc = !branch_taken;
    end else if (branch_taken) begin
      e_fl1 = 1'b1;
    end
  endtask

  task automatic compare_all();
    model_comb();
    check_eq("pc_stall", pc_stall, e_pc);
    check_eq("ifid_stall", ifid_stall, e_ifid);
    check_eq("idexe_stall", idexe_stall, e_idexe);
    check_eq("exemem_stall", exemem_stall, e_exemem);
    check_eq("ifid_flush", ifid_flush, e_fl1);
    check_eq("idexe_flush", idexe_flush, e_fl2);
    check_eq("fwdA", fwdA, e_fa);
    check_eq("fwdB", fwdB, e_fb);
    check_eq("mem_err", mem_err, m_err);
    check_eq("fsm_wait", dbg_state, m_wait);
    if (exp_q.size() == 0) check_eq("sb_empty", 0, 1);
    else check_eq("stall_cnt", stall_cnt, exp_q[0]);
  endtask

  // Advance the model across the coming rising edge.
  task automatic model_advance();
    int nxt;
    model_comb();
    if (!rst) begin
      model_reset();
      return;
    end
    nxt = int'(exp_q.pop_front()) + (e_pc ? 1 : 0);
    if (nxt > 65535) nxt = 65535;
    exp_q.push_back(16'(nxt));
    m_err = 1'b0;
    if (!m_wait) begin
      if (mem_req && !mem_ready) begin
        m_wait   = 1'b1;
        m_waited = 0;
      end
    end else if (mem_ready) begin
      m_wait = 1'b0;
    end else if (m_waited == 255) begin
      m_wait = 1'b0;
      m_err  = 1'b1;
    end else begin
      m_waited++;
    end
  endtask

  // Inputs change 1ns after posedge; outputs compared 4ns after posedge.
  task automatic step();
    #3;
    compare_all();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic [4:0] ed, input logic ealu, input logic emem,
                       input logic [4:0] md, input logic malu, input logic mmem,
                       input logic req, input logic rdy, input logic br);
    id_rs = rs; id_rt = rt; id_useRs = urs; id_useRt = urt;
    exe_WriteRegDst = ed; exe_ALUToReg = ealu; exe_MemToReg = emem;
    mem_WriteRegDst = md; mem_ALUToReg = malu; mem_MemToReg = mmem;
    mem_req = req; mem_ready = rdy; branch_taken = br;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // load-use on rs=r3, then the load moves to MEM
    drive(3, 0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0); step();
    drive(3, 0, 1, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0); step();
    // ALU RAW on rt=r5 in EXE, then in MEM
    drive(0, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 5, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0); step();
    // both operands, EXE over MEM priority
    drive(6, 6, 1, 1, 6, 1, 0, 6, 1, 0, 0, 0, 0); step();
    // r0 never matches; unused operand never matches
    drive(0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0); step();
    drive(7, 7, 0, 0, 7, 1, 1, 7, 1, 0, 0, 0, 0); step();
    // branch with load-use hazard, then branch alone
    drive(3, 0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 1); step();
    drive(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    // memory wait of 3 cycles, release on ready
    repeat (3) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    // structural conflict with and without branch
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step();
    // freeze overrides hazard and branch
    drive(3, 0, 1, 0, 3, 0, 1, 0, 0, 0, 1, 0, 1); step();
    drive(3, 0, 1, 0, 3, 0, 1, 0, 0, 0, 1, 1, 1); step();
    // timeout
    repeat (262) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();
    // reset asserted mid-wait
    repeat (5) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step(); end
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    step();
    step();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      step();
    end
    // stall counter saturation
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (65600) step();
    #3;
    check_eq("stall_cnt_sat", stall_cnt, 16'hFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
